// File: rtl/hazard_pkg.sv
// Shared types for the hazard control unit: FSM states and the pipeline control word.
package hazard_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLStall,
    StFlush
  } state_e;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic mux_hazard;
  } ctrl_t;

  localparam ctrl_t CTRL_RUN   = '{pc_write: 1'b1, if_id_write: 1'b1,
                                   if_id_flush: 1'b0, mux_hazard: 1'b0};
  localparam ctrl_t CTRL_STALL = '{pc_write: 1'b0, if_id_write: 1'b0,
                                   if_id_flush: 1'b0, mux_hazard: 1'b1};
  localparam ctrl_t CTRL_FLUSH = '{pc_write: 1'b1, if_id_write: 1'b1,
                                   if_id_flush: 1'b1, mux_hazard: 1'b1};

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/hazard_control_unit.sv
// Sequential hazard controller: multi-cycle load-use stalls, HI/LO busy interlock,
// multi-slot control-hazard flush and saturating stall/flush counters.
module hazard_control_unit
  import hazard_pkg::*;
#(
  parameter int unsigned REG_W         = 5,
  parameter int unsigned LOAD_LAT      = 1,
  parameter int unsigned MULDIV_CYCLES = 8,
  parameter int unsigned FLUSH_SLOTS   = 1,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [REG_W-1:0] rs_if_id,
  input  logic [REG_W-1:0] rt_if_id,
  input  logic             uses_rt_if_id,
  input  logic             reads_hilo_if_id,
  input  logic [REG_W-1:0] rt_id_ex,
  input  logic             mem_read_id_ex,
  input  logic             muldiv_start_id_ex,
  input  logic             branch_taken,
  input  logic             jump,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             mux_hazard,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_cycles
);

  localparam int unsigned BusyW = $clog2(MULDIV_CYCLES);
  localparam int unsigned ScntW = $clog2(LOAD_LAT + 1);
  localparam int unsigned FcntW = $clog2(FLUSH_SLOTS + 1);

  state_e           state_d, state_q;
  logic [ScntW-1:0] scnt_d, scnt_q;
  logic [FcntW-1:0] fcnt_d, fcnt_q;
  logic [BusyW-1:0] busy_d, busy_q;
  ctrl_t            ctrl;
  logic             lu, hb;

  assign lu = mem_read_id_ex && (rt_id_ex != '0) &&
              ((rs_if_id == rt_id_ex) || (uses_rt_if_id && (rt_if_id == rt_id_ex)));
  assign hb = (busy_q != '0) && reads_hilo_if_id;

  // Busy counter runs independently of the FSM, including during load-use stalls.
  always_comb begin
    busy_d = busy_q;
    if (muldiv_start_id_ex)  busy_d = BusyW'(MULDIV_CYCLES - 1);
    else if (busy_q != '0)   busy_d = busy_q - 1'b1;
  end

  always_comb begin
    state_d = state_q;
    scnt_d  = scnt_q;
    fcnt_d  = fcnt_q;
    ctrl    = CTRL_RUN;
    unique case (state_q)
      StIdle: begin
        if (lu) begin
          ctrl = CTRL_STALL;
          if (LOAD_LAT > 1) begin
            state_d = StLStall;
            scnt_d  = ScntW'(LOAD_LAT - 1);
          end
        end else if (hb) begin
          ctrl = CTRL_STALL;
        end else if (branch_taken || jump) begin
          ctrl = CTRL_FLUSH;
          if (FLUSH_SLOTS > 1) begin
            state_d = StFlush;
            fcnt_d  = FcntW'(FLUSH_SLOTS - 2);
          end
        end
      end
      // scnt counts remaining stall cycles; the entry cycle in StIdle was the first.
      StLStall: begin
        ctrl   = CTRL_STALL;
        scnt_d = scnt_q - 1'b1;
        if (scnt_q <= ScntW'(1)) state_d = StIdle;
      end
      StFlush: begin
        ctrl = CTRL_FLUSH;
        if (fcnt_q == '0) state_d = StIdle;
        else              fcnt_d  = fcnt_q - 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      scnt_q  <= '0;
      fcnt_q  <= '0;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      scnt_q  <= scnt_d;
      fcnt_q  <= fcnt_d;
      busy_q  <= busy_d;
    end
  end

  assign pc_write    = ctrl.pc_write;
  assign if_id_write = ctrl.if_id_write;
  assign if_id_flush = ctrl.if_id_flush;
  assign mux_hazard  = ctrl.mux_hazard;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i   (clock),
    .rst_ni  (reset),
    .inc_i   (!ctrl.pc_write),
    .count_o (stall_cycles)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk_i   (clock),
    .rst_ni  (reset),
    .inc_i   (ctrl.if_id_flush),
    .count_o (flush_cycles)
  );

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit with LOAD_LAT=2, MULDIV_CYCLES=8, FLUSH_SLOTS=2, CNT_W=4.
module tb_hazard_control_unit;

  localparam logic [3:0] RUN   = 4'b1100; // {pc_write, if_id_write, if_id_flush, mux_hazard}
  localparam logic [3:0] STALL = 4'b0001;
  localparam logic [3:0] FLUSH = 4'b1111;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [4:0] rs_if_id = '0, rt_if_id = '0, rt_id_ex = '0;
  logic       uses_rt_if_id = 1'b0, reads_hilo_if_id = 1'b0, mem_read_id_ex = 1'b0;
  logic       muldiv_start_id_ex = 1'b0, branch_taken = 1'b0, jump = 1'b0;
  logic       pc_write, if_id_write, if_id_flush, mux_hazard;
  logic [3:0] stall_cycles, flush_cycles;

  int num_checks = 0;
  int num_errors = 0;

  hazard_control_unit #(
    .REG_W(5), .LOAD_LAT(2), .MULDIV_CYCLES(8), .FLUSH_SLOTS(2), .CNT_W(4)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .rs_if_id           (rs_if_id),
    .rt_if_id           (rt_if_id),
    .uses_rt_if_id      (uses_rt_if_id),
    .reads_hilo_if_id   (reads_hilo_if_id),
    .rt_id_ex           (rt_id_ex),
    .mem_read_id_ex     (mem_read_id_ex),
    .muldiv_start_id_ex (muldiv_start_id_ex),
    .branch_taken       (branch_taken),
    .jump               (jump),
    .pc_write           (pc_write),
    .if_id_write        (if_id_write),
    .if_id_flush        (if_id_flush),
    .mux_hazard         (mux_hazard),
    .stall_cycles       (stall_cycles),
    .flush_cycles       (flush_cycles)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    num_checks++;
    if (got !== exp) begin
      num_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_ctrl(input string tag, input logic [3:0] exp);
    #1;
    check_eq(tag, {28'd0, pc_write, if_id_write, if_id_flush, mux_hazard}, {28'd0, exp});
  endtask

  task automatic set_lu(input logic on);
    mem_read_id_ex = on;
    rt_id_ex       = on ? 5'd8 : 5'd0;
    rs_if_id       = on ? 5'd8 : 5'd0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #2;
    reset = 1'b1;
    tick();
  endtask

  initial begin
    // Reset aborts an in-progress load-use stall.
    #2;
    reset = 1'b1;
    tick();
    set_lu(1'b1);
    check_ctrl("lu_first", STALL);
    tick();
    set_lu(1'b0);
    check_ctrl("lu_in_lstall", STALL);
    reset = 1'b0;
    check_ctrl("reset_async_ctrl", RUN);
    check_eq("reset_stall_cnt", 32'(stall_cycles), 32'd0);
    reset = 1'b1;
    tick();
    check_ctrl("after_reset_idle", RUN);
    check_eq("after_reset_flush_cnt", 32'(flush_cycles), 32'd0);

    // LOAD_LAT=2: exactly two stall cycles.
    set_lu(1'b1);
    check_ctrl("ll_cycle1", STALL);
    tick();
    set_lu(1'b0);
    check_ctrl("ll_cycle2", STALL);
    tick();
    check_ctrl("ll_done", RUN);
    check_eq("ll_stall_cnt", 32'(stall_cycles), 32'd2);

    // $zero destination and unused RT never stall.
    mem_read_id_ex = 1'b1; rt_id_ex = 5'd0; rs_if_id = 5'd0;
    check_ctrl("lu_zero_reg", RUN);
    rt_id_ex = 5'd8; rs_if_id = 5'd3; rt_if_id = 5'd8; uses_rt_if_id = 1'b0;
    check_ctrl("lu_rt_unused", RUN);
    uses_rt_if_id = 1'b1;
    check_ctrl("lu_rt_used", STALL);
    tick();
    mem_read_id_ex = 1'b0; uses_rt_if_id = 1'b0; rt_if_id = '0; rt_id_ex = '0; rs_if_id = '0;
    tick();
    check_eq("rt_stall_cnt", 32'(stall_cycles), 32'd4);

    // HI/LO interlock: 7 stall cycles after a MULT/DIV start.
    do_reset();
    muldiv_start_id_ex = 1'b1;
    tick();
    muldiv_start_id_ex = 1'b0;
    reads_hilo_if_id   = 1'b1;
    for (int i = 0; i < 7; i++) begin
      check_ctrl($sformatf("hb_stall_%0d", i), STALL);
      tick();
    end
    check_ctrl("hb_released", RUN);
    check_eq("hb_stall_cnt", 32'(stall_cycles), 32'd7);
    reads_hilo_if_id   = 1'b0;
    muldiv_start_id_ex = 1'b1;
    tick();
    muldiv_start_id_ex = 1'b0;
    check_ctrl("hb_non_hilo", RUN);
    for (int i = 0; i < 8; i++) tick();

    // FLUSH_SLOTS=2: two flush cycles, load-use in the second is ignored.
    do_reset();
    jump = 1'b1;
    check_ctrl("flush_slot1", FLUSH);
    tick();
    jump = 1'b0;
    set_lu(1'b1);
    check_ctrl("flush_slot2_ignore_lu", FLUSH);
    tick();
    set_lu(1'b0);
    check_ctrl("flush_done", RUN);
    check_eq("flush_cnt", 32'(flush_cycles), 32'd2);
    check_eq("flush_no_stall_cnt", 32'(stall_cycles), 32'd0);

    // Load-use beats a taken branch.
    set_lu(1'b1);
    branch_taken = 1'b1;
    check_ctrl("lu_beats_branch", STALL);
    tick();
    set_lu(1'b0);
    check_ctrl("lu_branch_lstall", STALL);
    tick();
    branch_taken = 1'b0;
    check_eq("lu_branch_flush_cnt", 32'(flush_cycles), 32'd2);
    check_eq("lu_branch_stall_cnt", 32'(stall_cycles), 32'd2);

    // 20 more stall cycles saturate the 4-bit counter at 15.
    set_lu(1'b1);
    for (int i = 0; i < 20; i++) tick();
    set_lu(1'b0);
    check_eq("sat_stall_cnt", 32'(stall_cycles), 32'd15);
    tick();
    tick();
    check_eq("sat_hold", 32'(stall_cycles), 32'd15);
    check_ctrl("sat_idle", RUN);

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
